// File: rtl/formation_motion_controller.sv
// Alien formation pacing: counts frame ticks, steps/drops the formation origin,
// and latches the terminal landed / cleared conditions.
module formation_motion_controller #(
  parameter int NUM_ROWS         = 2,
  parameter int NUM_COLUMNS      = 4,
  parameter int ALIEN_SPACING_X  = 64,
  parameter int ALIEN_SPACING_Y  = 32,
  parameter int ALIEN_WIDTH      = 32,
  parameter int ALIEN_HEIGHT     = 16,
  parameter int START_X          = 100,
  parameter int START_Y          = 50,
  parameter int SCREEN_WIDTH     = 640,
  parameter int STEP_X           = 8,
  parameter int DROP_Y           = 16,
  parameter int LAND_Y           = 400,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIEN = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  frame_tick,
  input  logic                                  enable,
  input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
  output logic [15:0]                           formation_x,
  output logic [15:0]                           formation_y,
  output logic                                  movement_direction,
  output logic                                  step_pulse,
  output logic                                  dropped,
  output logic                                  landed,
  output logic                                  cleared
);
  localparam int CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int NW = $clog2(NUM_ROWS*NUM_COLUMNS + 1);

  typedef enum logic [1:0] {RUN, LANDED, CLEARED} state_e;

  state_e            state_q, state_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic              dir_q, dir_d, step_q, step_d, drop_q, drop_d;

  logic [NW-1:0]          alive_count;
  logic [CW-1:0]          leftmost_col, rightmost_col;
  logic [RW-1:0]          bottom_row;
  logic [NUM_COLUMNS-1:0] col_any;
  logic [15:0]            period;
  logic [16:0]            left_edge, right_edge, land_edge, tick_nxt;
  logic                   due, hit_edge;

  always_comb begin
    alive_count   = '0;
    leftmost_col  = '0;
    rightmost_col = '0;
    bottom_row    = '0;
    col_any       = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++)
        alive_count = alive_count + NW'(alive_matrix[r][c]);
      if (|alive_matrix[r]) bottom_row = RW'(r);
      col_any = col_any | alive_matrix[r];
    end
    for (int c = NUM_COLUMNS-1; c >= 0; c--)
      if (col_any[c]) leftmost_col = CW'(c);
    for (int c = 0; c < NUM_COLUMNS; c++)
      if (col_any[c]) rightmost_col = CW'(c);
  end

  assign period     = 16'(MIN_PERIOD) + 16'(alive_count) * 16'(PERIOD_PER_ALIEN);
  assign left_edge  = {1'b0, x_q} + 17'(leftmost_col) * 17'(ALIEN_SPACING_X);
  assign right_edge = {1'b0, x_q} + 17'(rightmost_col) * 17'(ALIEN_SPACING_X) + 17'(ALIEN_WIDTH);
  // Bottom edge evaluated at the post-drop Y so landing coincides with the drop.
  assign land_edge  = {1'b0, y_q} + 17'(DROP_Y) + 17'(bottom_row) * 17'(ALIEN_SPACING_Y)
                    + 17'(ALIEN_HEIGHT);
  assign tick_nxt   = {1'b0, tick_cnt_q} + 17'd1;
  assign due        = tick_nxt >= {1'b0, period};
  assign hit_edge   = dir_q ? (right_edge + 17'(STEP_X) > 17'(SCREEN_WIDTH))
                            : (left_edge < 17'(STEP_X));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    drop_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (alive_count == '0) begin
          state_d = CLEARED;
        end else if (frame_tick && enable) begin
          if (due) begin
            tick_cnt_d = '0;
            step_d     = 1'b1;
            if (hit_edge) begin
              drop_d = 1'b1;
              y_d    = y_q + 16'(DROP_Y);
              dir_d  = ~dir_q;
              if (land_edge >= 17'(LAND_Y)) state_d = LANDED;
            end else if (dir_q) begin
              x_d = x_q + 16'(STEP_X);
            end else begin
              x_d = x_q - 16'(STEP_X);
            end
          end else begin
            tick_cnt_d = tick_nxt[15:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      tick_cnt_q <= '0;
      x_q        <= 16'(START_X);
      y_q        <= 16'(START_Y);
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      drop_q     <= drop_d;
    end
  end

  assign formation_x        = x_q;
  assign formation_y        = y_q;
  assign movement_direction = dir_q;
  assign step_pulse         = step_q;
  assign dropped            = drop_q;
  assign landed             = (state_q == LANDED);
  assign cleared            = (state_q == CLEARED);
endmodule

// File: tb/tb_formation_motion_controller.sv
// Directed bench: a behavioural model pushes expected steps on each driven tick,
// which are popped and compared when the DUT pulses step_pulse.
module tb_formation_motion_controller;
  localparam int NR = 2;
  localparam int NC = 4;

  typedef struct {int x; int y; int dir; int dr;} exp_t;

  logic clk, rst_n, frame_tick, enable;
  logic [NR-1:0][NC-1:0] alive;
  logic [15:0] fx, fy, fx2, fy2;
  logic dir, sp, dr, ld, cl, dir2, sp2, dr2, ld2, cl2;

  int tests = 0, fails = 0;
  exp_t q[$];
  int m_x, m_y, m_dir, m_cnt, m_term;
  logic prev_sp;
  int cnt2, snap2;

  formation_motion_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .alive_matrix(alive), .formation_x(fx), .formation_y(fy),
    .movement_direction(dir), .step_pulse(sp), .dropped(dr),
    .landed(ld), .cleared(cl));

  formation_motion_controller #(.LAND_Y(100)) dut_land (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .alive_matrix(alive), .formation_x(fx2), .formation_y(fy2),
    .movement_direction(dir2), .step_pulse(sp2), .dropped(dr2),
    .landed(ld2), .cleared(cl2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 100; m_y = 50; m_dir = 1; m_cnt = 0; m_term = 0;
    q.delete();
    prev_sp = 1'b0;
  endtask

  // Reference behaviour for one driven frame tick.
  task automatic model_tick();
    int lc, rc, br, n, per, edge_v;
    exp_t e;
    if (m_term) return;
    if (alive == '0) begin m_term = 1; return; end
    if (!enable) return;
    lc = -1; rc = 0; br = 0; n = $countones(alive);
    for (int c = 0; c < NC; c++)
      if (alive[0][c] | alive[1][c]) begin
        if (lc < 0) lc = c;
        rc = c;
      end
    for (int r = 0; r < NR; r++) if (|alive[r]) br = r;
    per = 2 + 2 * n;
    m_cnt++;
    if (m_cnt < per) return;
    m_cnt = 0;
    e.dr = 0;
    if (m_dir == 1) begin
      edge_v = m_x + rc * 64 + 32;
      if (edge_v + 8 > 640) e.dr = 1; else m_x = m_x + 8;
    end else begin
      edge_v = m_x + lc * 64;
      if (edge_v < 8) e.dr = 1; else m_x = m_x - 8;
    end
    if (e.dr == 1) begin
      m_y = m_y + 16;
      m_dir = 1 - m_dir;
      if (m_y + br * 32 + 16 >= 400) m_term = 1;
    end
    e.x = m_x; e.y = m_y; e.dir = m_dir;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    frame_tick = 1'b1;
    model_tick();
    @(posedge clk); #1;
    frame_tick = 1'b0;
    if (prev_sp) chk("double_step", sp, 0);
    prev_sp = sp;
    if (sp2) cnt2++;
    if (sp) begin
      if (q.size() == 0) chk("unexpected_step", sp, 0);
      else begin
        e = q.pop_front();
        chk("step_x", fx, e.x);
        chk("step_y", fy, e.y);
        chk("step_dir", dir, e.dir);
        chk("step_dropped", dr, e.dr);
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("missing_step", sp, 1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; frame_tick = 1'b0;
    #1;
    chk("rst_x", fx, 100);
    chk("rst_y", fy, 50);
    chk("rst_dir", dir, 1);
    chk("rst_step", sp, 0);
    chk("rst_dropped", dr, 0);
    chk("rst_landed", ld, 0);
    chk("rst_cleared", cl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1; frame_tick = 1'b0; enable = 1'b1; alive = '1; cnt2 = 0;
    model_reset();
    do_reset();

    // First step after a full period of 18 ticks
    repeat (17) tick();
    chk("no_step_before_18", fx, 100);
    tick();
    chk("step_at_18", sp, 1);
    chk("x_after_first", fx, 108);
    chk("y_after_first", fy, 50);

    // Run to the 40th step: right-edge drop at x=412
    repeat (39 * 18) tick();
    chk("drop_pulse", dr, 1);
    chk("drop_x", fx, 412);
    chk("drop_y", fy, 66);
    chk("drop_dir", dir, 0);
    chk("land_at_drop", ld2, 1);
    chk("land_y", fy2, 66);
    chk("land_dropped", dr2, 1);
    snap2 = cnt2;
    repeat (18) tick();
    chk("move_left", fx, 404);
    chk("landed_frozen_x", fx2, 412);
    chk("landed_frozen_y", fy2, 66);
    chk("landed_no_steps", cnt2, snap2);
    chk("landed_sticky", ld2, 1);
    chk("main_not_landed", ld, 0);

    // Period shrink mid-period: only alive[0][0] remains
    do_reset();
    repeat (5) tick();
    alive = '0; alive[0][0] = 1'b1;
    tick();
    chk("shrink_step", sp, 1);
    chk("shrink_x", fx, 108);
    repeat (62 * 4) tick();
    chk("narrow_x", fx, 604);
    repeat (4) tick();
    chk("narrow_drop", dr, 1);
    chk("narrow_drop_x", fx, 604);
    chk("narrow_drop_y", fy, 66);

    // Wave cleared on the cycle a step is due
    repeat (3) tick();
    alive = '0;
    chk("cleared_pre", cl, 0);
    tick();
    chk("cleared_no_step", sp, 0);
    chk("cleared_set", cl, 1);
    alive = '1;
    repeat (20) tick();
    chk("cleared_sticky", cl, 1);
    chk("cleared_frozen_x", fx, 604);

    // Disabled ticks are ignored; async reset mid-run restarts the period
    do_reset();
    enable = 1'b0;
    repeat (30) tick();
    chk("disabled_x", fx, 100);
    enable = 1'b1;
    repeat (10) tick();
    do_reset();
    repeat (17) tick();
    chk("post_rst_no_step", fx, 100);
    tick();
    chk("post_rst_step", sp, 1);
    chk("post_rst_x", fx, 108);

    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
